i2c_target: RTL and testbench
=============================

# i2c_target

Responder (slave) end of the I2C bus driven by our I2C master core. It listens on a bused SCL/SDA pair, detects START/STOP, and matches a 7-bit device address. Write bytes are delivered to the fabric as a byte stream; read bytes are taken from the fabric through a request/data pair. It sits behind a slot wrapper or drives a local register bank directly, and is open-drain on SDA only. It never stretches SCL.

## Interface

- ADDR, 7'h42, 7-bit device address this target answers to
- clk  input  1  system clock; must be ≥ 20× SCL frequency
- reset  input  1  asynchronous, active-high
- scl  input  1  bus clock from master (tri, externally pulled up)
- sda  inout  1  bus data; driven only to 0, otherwise 'z
- rx_data  output  8  last byte written by master, valid when rx_tick
- rx_tick  output  1  one-clk pulse: new write byte in rx_data
- tx_data  input  8  next byte to return on a master read; must be held stable while tx_req is high
- tx_req  output  1  one-clk pulse: tx_data is latched this cycle
- start_tick  output  1  one-clk pulse on START/repeated START
- stop_tick  output  1  one-clk pulse on STOP
- busy  output  1  high from address match until STOP/START/NACK end

## Operation

- Input conditioning: scl and sda each pass through a 2-FF synchronizer, then a 1-FF delay register for edge detection. All bus events are derived from synchronized signals only.
- START: synced sda falls while synced scl is high. STOP: synced sda rises while synced scl is high. Both are recognised in every state and override it:
  - START → ADDR with bit count cleared and sda released.
  - STOP → IDLE with sda released.
- Bits are sampled on the synced scl rising edge. The target changes its SDA drive only on the synced scl falling edge.
- States:
  - IDLE: sda released; wait for START.
  - ADDR: shift 8 bits MSB first (7 address bits + R/W). After the 8th rise, compare the upper 7 bits with ADDR.
    - Mismatch → IGNORE.
    - Match → on the next scl fall drive sda=0 and enter ADDR_ACK. busy=1.
  - ADDR_ACK: hold sda=0 through the ACK clock. On the following scl fall:
    - R/W=0 → release sda and enter WR_DATA.
    - R/W=1 → pulse tx_req, latch tx_data, drive MSB, and enter RD_DATA.
  - WR_DATA: shift 8 bits. On the 8th rise, load rx_data and pulse rx_tick. On the next fall, drive sda=0 and enter WR_ACK. Every write byte is ACKed.
  - WR_ACK: on the next fall, release sda and return to WR_DATA.
  - RD_DATA: on each fall after a bit, drive the next bit (0 → drive low, 1 → release). After the 8th bit's fall, release sda and enter RD_ACK.
  - RD_ACK: sample master ACK on the scl rise, then act on the following fall:
    - ACK (sda=0) → pulse tx_req, latch tx_data, drive MSB, and enter RD_DATA.
    - NACK → IGNORE with busy=0.
  - IGNORE: sda released; wait for START or STOP.
- Bit counter is 3 bits wide and wraps from 7 to 0 at the byte boundary. The shift register is 8 bits.
- General call (address 0) is not supported and is treated as a mismatch.

## Timing

- Reset values: sda released ('z), rx_data=0, rx_tick=0, tx_req=0, start_tick=0, stop_tick=0, busy=0, state=IDLE.
- Reset asserted mid-transfer releases sda asynchronously on the same edge.
- Event latency is 3 clk from a pin change to the internal edge flag (2 sync + 1 detect). Output pulses are registered and assert 1 clk later.
- SDA drive change occurs 4 clk after the physical scl fall. This is well inside the low phase at the required clock ratio.
- rx_tick asserts 4 clk after the 8th scl rise of a write byte. rx_data is stable from that cycle until the next rx_tick.
- tx_req coincides with the latch of tx_data, 4 clk after the scl fall that ends an ACK slot.
- If START and an scl edge are flagged in the same clk, START wins.
- SDA transitions while scl is high during a data bit are always START/STOP, never data.

## Test plan

- Write, address match: START, 0x84 (0x42, W), 0xA5, 0x3C, STOP → ACK on all three bytes; rx_tick twice with rx_data=0xA5 then 0x3C; start_tick and stop_tick once each; busy 1→0 at STOP.
- Address mismatch: START, 0x86 (0x43, W), 0xFF, STOP → sda never driven low; no rx_tick; busy stays 0.
- Read with ACK then NACK: tx_data=0x96 then 0x5A on successive tx_req; START, 0x85, master ACKs the first byte and NACKs the second → bus carries 0x96, 0x5A; tx_req pulses twice; state IGNORE after NACK, then IDLE at STOP.
- Repeated START: write 0x84, 0x11, then START, 0x85, read one byte with NACK, STOP → rx_data=0x11; start_tick twice; read phase returns the latched tx_data.
- Reset mid-read: assert reset while a 0 bit is being driven → sda released immediately; all outputs 0; the next full write transaction is received correctly.
- STOP mid-byte: STOP after 4 bits of a write byte → no rx_tick; IDLE; busy=0; sda released.

Source files
------------

// File: rtl/i2c_target.sv
// i2c_target: I2C responder with a 7-bit device address.
// Write bytes from the master appear on rx_data with a one-clk rx_tick.
// Read bytes are requested from the fabric with a one-clk tx_req, and tx_data
// is latched in that same cycle. SDA is open-drain: the only values driven
// are 0 and 'z. SCL is never stretched.
// Ports:
//   clk, reset   system clock; asynchronous active-high reset
//   scl          bus clock input
//   sda          bus data (open-drain inout)
//   rx_data      last byte written by the master; rx_tick marks a new byte
//   tx_data      byte returned on a master read; tx_req marks its latch cycle
//   start_tick   pulse on START or repeated START
//   stop_tick    pulse on STOP
//   busy         high from address match until STOP, START or read NACK
module i2c_target #(
  parameter logic [6:0] ADDR = 7'h42
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] rx_data,
  output logic       rx_tick,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       start_tick,
  output logic       stop_tick,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_IGNORE
  } state_t;

  logic scl_s1, scl_s2, scl_d, sda_s1, sda_s2, sda_d;
  logic scl_rise, scl_fall, start_ev, stop_ev;

  // Two-stage synchronizer, delay stage, and registered event flags. The
  // synchronizers reset to the idle-high bus level so that reset release
  // does not produce a false edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_s1   <= 1'b1;
      scl_s2   <= 1'b1;
      scl_d    <= 1'b1;
      sda_s1   <= 1'b1;
      sda_s2   <= 1'b1;
      sda_d    <= 1'b1;
      scl_rise <= 1'b0;
      scl_fall <= 1'b0;
      start_ev <= 1'b0;
      stop_ev  <= 1'b0;
    end else begin
      scl_s1   <= scl;
      scl_s2   <= scl_s1;
      scl_d    <= scl_s2;
      sda_s1   <= sda;
      sda_s2   <= sda_s1;
      sda_d    <= sda_s2;
      scl_rise <= scl_s2 & ~scl_d;
      scl_fall <= ~scl_s2 & scl_d;
      start_ev <= scl_s2 & scl_d & ~sda_s2 & sda_d;
      stop_ev  <= scl_s2 & scl_d & sda_s2 & ~sda_d;
    end
  end

  state_t     state, state_n;
  logic [2:0] cnt, cnt_n;
  logic [7:0] shreg, shreg_n;
  logic       byte_done, byte_done_n;
  logic       rw, rw_n;
  logic       mack, mack_n;
  logic       sda_low, sda_low_n;
  logic       busy_n, rx_tick_n, tx_req_n, start_tick_n, stop_tick_n;
  logic [7:0] rx_data_n;

  assign sda = sda_low ? 1'b0 : 1'bz;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      shreg      <= '0;
      byte_done  <= 1'b0;
      rw         <= 1'b0;
      mack       <= 1'b0;
      sda_low    <= 1'b0;
      busy       <= 1'b0;
      rx_data    <= '0;
      rx_tick    <= 1'b0;
      tx_req     <= 1'b0;
      start_tick <= 1'b0;
      stop_tick  <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      shreg      <= shreg_n;
      byte_done  <= byte_done_n;
      rw         <= rw_n;
      mack       <= mack_n;
      sda_low    <= sda_low_n;
      busy       <= busy_n;
      rx_data    <= rx_data_n;
      rx_tick    <= rx_tick_n;
      tx_req     <= tx_req_n;
      start_tick <= start_tick_n;
      stop_tick  <= stop_tick_n;
    end
  end

  // byte_done marks "8th rise seen, act on the next fall", so the fall that
  // follows START (bit count also 0) is not mistaken for a byte boundary.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    shreg_n      = shreg;
    byte_done_n  = byte_done;
    rw_n         = rw;
    mack_n       = mack;
    sda_low_n    = sda_low;
    busy_n       = busy;
    rx_data_n    = rx_data;
    rx_tick_n    = 1'b0;
    tx_req_n     = 1'b0;
    start_tick_n = 1'b0;
    stop_tick_n  = 1'b0;
    if (start_ev) begin
      state_n      = S_ADDR;
      cnt_n        = '0;
      byte_done_n  = 1'b0;
      sda_low_n    = 1'b0;
      busy_n       = 1'b0;
      start_tick_n = 1'b1;
    end else if (stop_ev) begin
      state_n     = S_IDLE;
      byte_done_n = 1'b0;
      sda_low_n   = 1'b0;
      busy_n      = 1'b0;
      stop_tick_n = 1'b1;
    end else begin
      case (state)
        S_IDLE, S_IGNORE: sda_low_n = 1'b0;
        S_ADDR: begin
          if (scl_rise) begin
            shreg_n = {shreg[6:0], sda_d};
            cnt_n   = cnt + 3'd1;
            if (cnt == 3'd7) begin
              if (shreg[6:0] == ADDR && shreg[6:0] != 7'd0) begin
                byte_done_n = 1'b1;
                rw_n        = sda_d;
                busy_n      = 1'b1;
              end else begin
                state_n = S_IGNORE;
              end
            end
          end else if (scl_fall && byte_done) begin
            byte_done_n = 1'b0;
            sda_low_n   = 1'b1;
            state_n     = S_ADDR_ACK;
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            cnt_n = '0;
            if (rw) begin
              tx_req_n  = 1'b1;
              shreg_n   = tx_data;
              sda_low_n = ~tx_data[7];
              state_n   = S_RD_DATA;
            end else begin
              sda_low_n = 1'b0;
              state_n   = S_WR_DATA;
            end
          end
        end
        S_WR_DATA: begin
          if (scl_rise) begin
            shreg_n = {shreg[6:0], sda_d};
            cnt_n   = cnt + 3'd1;
            if (cnt == 3'd7) begin
              rx_data_n   = {shreg[6:0], sda_d};
              rx_tick_n   = 1'b1;
              byte_done_n = 1'b1;
            end
          end else if (scl_fall && byte_done) begin
            byte_done_n = 1'b0;
            sda_low_n   = 1'b1;
            state_n     = S_WR_ACK;
          end
        end
        S_WR_ACK: begin
          if (scl_fall) begin
            sda_low_n = 1'b0;
            cnt_n     = '0;
            state_n   = S_WR_DATA;
          end
        end
        S_RD_DATA: begin
          if (scl_rise) begin
            cnt_n = cnt + 3'd1;
            if (cnt == 3'd7) byte_done_n = 1'b1;
          end else if (scl_fall) begin
            if (byte_done) begin
              byte_done_n = 1'b0;
              sda_low_n   = 1'b0;
              state_n     = S_RD_ACK;
            end else begin
              shreg_n   = {shreg[6:0], 1'b0};
              sda_low_n = ~shreg[6];
            end
          end
        end
        S_RD_ACK: begin
          if (scl_rise) begin
            mack_n = ~sda_d;
          end else if (scl_fall) begin
            if (mack) begin
              tx_req_n  = 1'b1;
              shreg_n   = tx_data;
              sda_low_n = ~tx_data[7];
              cnt_n     = '0;
              state_n   = S_RD_DATA;
            end else begin
              sda_low_n = 1'b0;
              busy_n    = 1'b0;
              state_n   = S_IGNORE;
            end
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: bus-level bench for i2c_target. A bit-banged master drives
// SCL and an open-drain SDA (pulled up). Expected values come from the bus
// rules: the address byte is ACKed only for 7'h42, every write byte of an
// addressed transfer is ACKed and delivered, and read bytes carry tx_data in
// tx_req order.
module tb_i2c_target;
  localparam int unsigned Q = 10;  // quarter SCL period in clk cycles

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  logic [7:0] tx_data = 8'h00;
  wire        sda;
  logic [7:0] rx_data;
  logic       rx_tick, tx_req, start_tick, stop_tick, busy;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  i2c_target #(.ADDR(7'h42)) dut (
    .clk(clk), .reset(reset), .scl(scl), .sda(sda),
    .rx_data(rx_data), .rx_tick(rx_tick), .tx_data(tx_data), .tx_req(tx_req),
    .start_tick(start_tick), .stop_tick(stop_tick), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned n_rx = 0, n_txreq = 0, n_start = 0, n_stop = 0, n_dut_low = 0;
  logic [7:0] rx_log[$];

  always @(negedge clk) begin
    if (rx_tick) begin
      n_rx++;
      rx_log.push_back(rx_data);
    end
    if (tx_req) n_txreq++;
    if (start_tick) n_start++;
    if (stop_tick) n_stop++;
    if (sda === 1'b0 && !m_low) n_dut_low++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic bus_bit();
    return (sda === 1'b0) ? 1'b0 : 1'b1;
  endfunction

  task automatic clks(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic m_start();
    m_low = 1'b1; clks(Q); scl = 1'b0;
  endtask

  task automatic m_rstart();
    clks(Q); m_low = 1'b0; clks(Q); scl = 1'b1; clks(Q); m_low = 1'b1; clks(Q); scl = 1'b0;
  endtask

  task automatic m_stop();
    clks(Q); m_low = 1'b1; clks(Q); scl = 1'b1; clks(Q); m_low = 1'b0; clks(Q);
  endtask

  task automatic m_bit(input logic b, output logic r);
    clks(Q); m_low = ~b; clks(Q); scl = 1'b1; clks(Q); r = bus_bit(); clks(Q); scl = 1'b0;
  endtask

  task automatic m_write(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) m_bit(b[i], r);
    m_bit(1'b1, r);
    ack = ~r;
  endtask

  task automatic m_read(input logic ack, input logic [7:0] next_tx, output logic [7:0] v);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      m_bit(1'b1, r);
      v[i] = r;
    end
    tx_data = next_tx;
    m_bit(~ack, r);
  endtask

  initial begin
    logic        a, r, match, rw;
    logic [7:0]  v, d;
    logic [6:0]  addr;
    logic [7:0]  vals[4];
    logic [7:0]  exp_q[$];
    int unsigned b_rx, b_tx, b_st, b_sp, b_low, base, n;

    // Reset state
    clks(3);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_tick", rx_tick, 1'b0);
    check("rst_tx_req", tx_req, 1'b0);
    check("rst_start_tick", start_tick, 1'b0);
    check("rst_stop_tick", stop_tick, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_sda", bus_bit(), 1'b1);
    reset = 1'b0;
    clks(5);

    // Write with address match
    b_rx = n_rx; b_st = n_start; b_sp = n_stop; base = rx_log.size();
    m_start();
    m_write(8'h84, a); check("wr_addr_ack", a, 1'b1);
    check("wr_busy", busy, 1'b1);
    m_write(8'hA5, a); check("wr_d0_ack", a, 1'b1);
    m_write(8'h3C, a); check("wr_d1_ack", a, 1'b1);
    m_stop(); clks(6);
    check("wr_busy_after_stop", busy, 1'b0);
    check("wr_rx_count", n_rx - b_rx, 2);
    if (rx_log.size() >= base + 2) begin
      check("wr_rx0", rx_log[base], 8'hA5);
      check("wr_rx1", rx_log[base + 1], 8'h3C);
    end
    check("wr_start_count", n_start - b_st, 1);
    check("wr_stop_count", n_stop - b_sp, 1);

    // Address mismatch
    b_rx = n_rx; b_low = n_dut_low;
    m_start();
    m_write(8'h86, a); check("mm_addr_nack", a, 1'b0);
    check("mm_busy", busy, 1'b0);
    m_write(8'hFF, a); check("mm_data_nack", a, 1'b0);
    m_stop(); clks(6);
    check("mm_no_drive", n_dut_low - b_low, 0);
    check("mm_no_rx", n_rx - b_rx, 0);

    // Read, ACK then NACK
    b_tx = n_txreq;
    tx_data = 8'h96;
    m_start();
    m_write(8'h85, a); check("rd_addr_ack", a, 1'b1);
    m_read(1'b1, 8'h5A, v); check("rd_byte0", v, 8'h96);
    m_read(1'b0, 8'h00, v); check("rd_byte1", v, 8'h5A);
    clks(6);
    check("rd_busy_after_nack", busy, 1'b0);
    check("rd_released_after_nack", bus_bit(), 1'b1);
    m_stop(); clks(6);
    check("rd_txreq_count", n_txreq - b_tx, 2);

    // Repeated START: write then read
    b_rx = n_rx; b_st = n_start; b_sp = n_stop; base = rx_log.size();
    m_start();
    m_write(8'h84, a); check("rs_wr_addr_ack", a, 1'b1);
    m_write(8'h11, a); check("rs_wr_ack", a, 1'b1);
    m_rstart();
    d = 8'($urandom);
    tx_data = d;
    m_write(8'h85, a); check("rs_rd_addr_ack", a, 1'b1);
    m_read(1'b0, 8'h00, v); check("rs_rd_byte", v, d);
    m_stop(); clks(6);
    check("rs_rx_count", n_rx - b_rx, 1);
    check("rs_rx_data", rx_data, 8'h11);
    check("rs_start_count", n_start - b_st, 2);
    check("rs_stop_count", n_stop - b_sp, 1);

    // Reset while the target drives a 0 bit
    tx_data = 8'h3F;
    m_start();
    m_write(8'h85, a); check("mr_addr_ack", a, 1'b1);
    clks(6);
    check("mr_bit_driven_low", bus_bit(), 1'b0);
    reset = 1'b1;
    #1;
    check("mr_sda_released", bus_bit(), 1'b1);
    check("mr_busy", busy, 1'b0);
    check("mr_rx_data", rx_data, 8'h00);
    check("mr_pulses", {rx_tick, tx_req, start_tick, stop_tick}, 4'b0000);
    clks(3);
    reset = 1'b0;
    clks(Q); scl = 1'b1; clks(Q);
    b_rx = n_rx;
    m_start();
    m_write(8'h84, a); check("mr_wr_addr_ack", a, 1'b1);
    m_write(8'h77, a); check("mr_wr_ack", a, 1'b1);
    m_stop(); clks(6);
    check("mr_rx_count", n_rx - b_rx, 1);
    check("mr_rx_value", rx_data, 8'h77);

    // STOP after 4 bits of a write byte
    b_rx = n_rx; b_sp = n_stop;
    m_start();
    m_write(8'h84, a); check("sm_addr_ack", a, 1'b1);
    m_bit(1'b1, r); m_bit(1'b0, r); m_bit(1'b1, r); m_bit(1'b1, r);
    m_stop(); clks(6);
    check("sm_no_rx", n_rx - b_rx, 0);
    check("sm_busy", busy, 1'b0);
    check("sm_sda_released", bus_bit(), 1'b1);
    check("sm_stop_count", n_stop - b_sp, 1);

    // Randomized transactions against the bus-rule model
    for (int t = 0; t < 8; t++) begin
      addr  = ($urandom_range(0, 1) == 0) ? 7'h42 : 7'($urandom_range(0, 127));
      match = (addr == 7'h42);
      rw    = 1'($urandom_range(0, 1));
      n     = $urandom_range(1, 3);
      for (int k = 0; k < 4; k++) vals[k] = 8'($urandom);
      b_rx = n_rx; b_tx = n_txreq; base = rx_log.size();
      exp_q.delete();
      if (!rw) begin
        m_start();
        m_write({addr, 1'b0}, a); check("rnd_wr_addr_ack", a, match);
        for (int k = 0; k < int'(n); k++) begin
          m_write(vals[k], a); check("rnd_wr_ack", a, match);
          if (match) exp_q.push_back(vals[k]);
        end
        m_stop(); clks(6);
        check("rnd_wr_rx_count", n_rx - b_rx, exp_q.size());
        for (int k = 0; k < exp_q.size(); k++)
          if (rx_log.size() > base + k) check("rnd_wr_rx_data", rx_log[base + k], exp_q[k]);
      end else begin
        tx_data = vals[0];
        m_start();
        m_write({addr, 1'b1}, a); check("rnd_rd_addr_ack", a, match);
        for (int k = 0; k < int'(n); k++) begin
          m_read(k < int'(n) - 1, vals[k + 1], v);
          check("rnd_rd_byte", v, match ? vals[k] : 8'hFF);
        end
        m_stop(); clks(6);
        check("rnd_rd_txreq_count", n_txreq - b_tx, match ? n : 0);
      end
      check("rnd_busy_idle", busy, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
